core_seq_ctrl: RTL and testbench

Sequencer that owns the `Core` compute block's `en`/`addr` inputs. On a start pulse it runs a compute phase of exactly `RUN_CYCLES` enabled cycles, then idles `GAP_CYCLES` cycles. It then sweeps the result address space and samples `Core`'s single-bit `OUTPUT`, packs the bits MSB-first into bytes, and delivers them on a valid/ready stream. It sits between the top-level control/UART logic and `Core`, and replaces bench-driven sequencing of `en`/`addr`.

---
 rtl/core_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_core_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - sequences Core en/addr: compute run, gap, bit readout packed MSB-first into a byte stream
// Optional CORE_SEQ_ABORT_EN adds an abort input that returns the sequencer to IDLE.
module core_seq_ctrl #(
  parameter int RUN_CYCLES = 589831,
  parameter int GAP_CYCLES = 5,
  parameter int ADDR_W     = 11,
  parameter int NUM_BITS   = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              core_en,
  output logic [ADDR_W-1:0] core_addr,
  input  logic              core_out,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef CORE_SEQ_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int CNT_MAX = (RUN_CYCLES > GAP_CYCLES) ? RUN_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  RUN_LOAD = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    GAP,
    RD_ADDR,
    RD_SAMP,
    FLUSH,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx;
  logic [6:0]        shreg;
  logic              out_free;
  logic              accept;
  logic              abort_hit;

  assign accept   = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;

`ifdef CORE_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // core_addr is loaded on entry to RD_ADDR so Core's registered output is valid by RD_SAMP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      core_en   <= 1'b0;
      core_addr <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (abort_hit) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      core_en   <= 1'b0;
      core_addr <= '0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          core_en   <= 1'b0;
          core_addr <= '0;
          if (start) begin
            cnt     <= RUN_LOAD;
            core_en <= 1'b1;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            cnt     <= GAP_LOAD;
            core_en <= 1'b0;
            state   <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            idx       <= '0;
            core_addr <= '0;
            shreg     <= '0;
            state     <= RD_ADDR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_ADDR: begin
          core_addr <= idx;
          state     <= RD_SAMP;
        end
        RD_SAMP: begin
          if (idx[2:0] != 3'd7) begin
            shreg     <= {shreg[5:0], core_out};
            idx       <= idx + 1'b1;
            core_addr <= idx + 1'b1;
            state     <= RD_ADDR;
          end else if (out_free) begin
            out_data  <= {shreg, core_out};
            out_valid <= 1'b1;
            shreg     <= '0;
            if (idx == LAST_IDX) begin
              state <= FLUSH;
            end else begin
              idx       <= idx + 1'b1;
              core_addr <= idx + 1'b1;
              state     <= RD_ADDR;
            end
          end
          // Otherwise stall here with core_addr held; resampling is harmless.
        end
        FLUSH: begin
          if (accept) begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - scoreboard bench for core_seq_ctrl with a registered addr[0] Core model
module tb_core_seq_ctrl;

  localparam int RUN_CYCLES = 16;
  localparam int GAP_CYCLES = 5;
  localparam int ADDR_W     = 11;
  localparam int NUM_BITS   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              core_en;
  logic [ADDR_W-1:0] core_addr;
  logic              core_out = 1'b0;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
`ifdef CORE_SEQ_ABORT_EN
  logic              abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int en_last = -1;
  int done_cnt = 0;
  int valid_cnt = 0;
  int first_valid = -1;
  logic [7:0] exp_q[$];

  core_seq_ctrl #(
    .RUN_CYCLES(RUN_CYCLES),
    .GAP_CYCLES(GAP_CYCLES),
    .ADDR_W(ADDR_W),
    .NUM_BITS(NUM_BITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .core_en(core_en),
    .core_addr(core_addr),
    .core_out(core_out),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef CORE_SEQ_ABORT_EN
    ,
    .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    core_out <= core_addr[0];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and tracks en/done/valid activity.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_en) begin
        en_cnt++;
        en_last = cyc;
      end
      if (done) done_cnt++;
      if (out_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL byte_unexpected: got 0x%0h, expected no byte", out_data);
        end else begin
          check("byte", int'(out_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic clear_stats();
    en_cnt = 0;
    en_last = -1;
    done_cnt = 0;
    valid_cnt = 0;
    first_valid = -1;
  endtask

  task automatic do_start(output int s);
    @(posedge clk);
    #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic goto_cycle(input int target);
    for (int i = 0; i < 500 && cyc < target; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start_at(input int target);
    goto_cycle(target);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int s, input int exp_lat, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within 400 cycles, expected latency %0d", name, exp_lat);
    end else begin
      check(name, cyc - s, exp_lat);
    end
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 20000 cycles, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_core_en", int'(core_en), 0);
    check("rst_core_addr", int'(core_addr), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal run, out_ready high
    clear_stats();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    do_start(s);
    wait_done(s, 56, "nominal_done_latency");
    check("nominal_first_valid", first_valid - s, 38);
    check("nominal_en_cycles", en_cnt, 16);
    check("nominal_en_last", en_last - s, 16);
    repeat (3) @(negedge clk);
    check("nominal_done_pulses", done_cnt, 1);
    check("nominal_bytes_left", exp_q.size(), 0);
    check("nominal_busy_after", int'(busy), 0);

    // Back-pressure: ready low for 20 cycles from first out_valid
    clear_stats();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    do_start(s);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("stall_first_valid", cyc - s, 38);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), 8'h55);
      if (cyc - s >= 54) check("stall_addr", int'(core_addr), NUM_BITS - 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(s, 61, "stall_done_latency");
    repeat (3) @(negedge clk);
    check("stall_bytes_left", exp_q.size(), 0);
    check("stall_done_pulses", done_cnt, 1);

    // start re-pulsed during RUN and during RD_SAMP is ignored
    clear_stats();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    do_start(s);
    pulse_start_at(s + 5);
    pulse_start_at(s + 25);
    wait_done(s, 56, "repulse_done_latency");
    check("repulse_en_cycles", en_cnt, 16);
    repeat (40) @(negedge clk);
    check("repulse_done_pulses", done_cnt, 1);
    check("repulse_busy_after", int'(busy), 0);
    check("repulse_bytes_left", exp_q.size(), 0);

    // Asynchronous reset mid-readout, then a clean run
    clear_stats();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    do_start(s);
    goto_cycle(s + 30);
    check("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_core_en", int'(core_en), 0);
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_core_addr", int'(core_addr), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    do_start(s);
    wait_done(s, 56, "post_reset_done_latency");
    repeat (3) @(negedge clk);
    check("post_reset_bytes_left", exp_q.size(), 0);
    check("post_reset_en_cycles", en_cnt, 16);

`ifdef CORE_SEQ_ABORT_EN
    // Abort in cycle 8 of RUN
    clear_stats();
    do_start(s);
    goto_cycle(s + 8);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_core_en", int'(core_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_core_addr", int'(core_addr), 0);
    repeat (80) @(negedge clk);
    check("abort_done_pulses", done_cnt, 0);
    check("abort_valid_cycles", valid_cnt, 0);
    check("abort_en_cycles", en_cnt, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
